// File: rtl/det_count_display.sv
// Counts rising edges of the asynchronous detector output as a 3-digit BCD value
// and shows it on a multiplexed seven-segment display with leading-zero blanking.
module det_count_display #(
  parameter int REFRESH_BITS   = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        det,
  input  logic        clr,
  output logic [7:0]  seg,
  output logic [2:0]  an,
  output logic [11:0] cnt_bcd,
  output logic        ovf
);

  typedef enum logic [1:0] {
    DIG_UNITS = 2'd0,
    DIG_TENS  = 2'd1,
    DIG_HUNDS = 2'd2,
    DIG_BAD   = 2'd3
  } dig_e;

  logic                    det_s1, det_s2, det_prev;
  logic                    clr_s1, clr_s2;
  logic                    pulse;
  logic [3:0]              units, tens, hunds;
  logic [REFRESH_BITS-1:0] refresh;
  logic                    wrap;
  dig_e                    sel, sel_next;
  logic [2:0]              an_h, an_next;
  logic [7:0]              seg_h, seg_next;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b0111111;
      4'd1:    decode = 7'b0000110;
      4'd2:    decode = 7'b1011011;
      4'd3:    decode = 7'b1001111;
      4'd4:    decode = 7'b1100110;
      4'd5:    decode = 7'b1101101;
      4'd6:    decode = 7'b1111101;
      4'd7:    decode = 7'b0000111;
      4'd8:    decode = 7'b1111111;
      4'd9:    decode = 7'b1101111;
      default: decode = 7'b0000000;
    endcase
  endfunction

  // NOTE: every flop uses non-blocking assignment so the synchroniser chain
  // shifts by exactly one stage per edge regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      det_s1   <= 1'b0;
      det_s2   <= 1'b0;
      det_prev <= 1'b0;
      clr_s1   <= 1'b0;
      clr_s2   <= 1'b0;
    end else begin
      det_s1   <= det;
      det_s2   <= det_s1;
      det_prev <= det_s2;
      clr_s1   <= clr;
      clr_s2   <= clr_s1;
    end
  end

  assign pulse = det_s2 & ~det_prev;

  // Clear takes priority; a pulse coinciding with it is intentionally lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      units <= 4'd0;
      tens  <= 4'd0;
      hunds <= 4'd0;
      ovf   <= 1'b0;
    end else if (clr_s2) begin
      units <= 4'd0;
      tens  <= 4'd0;
      hunds <= 4'd0;
      ovf   <= 1'b0;
    end else if (pulse) begin
      if (units != 4'd9) begin
        units <= units + 4'd1;
      end else begin
        units <= 4'd0;
        if (tens != 4'd9) begin
          tens <= tens + 4'd1;
        end else begin
          tens <= 4'd0;
          if (hunds != 4'd9) begin
            hunds <= hunds + 4'd1;
          end else begin
            hunds <= 4'd0;
            ovf   <= 1'b1;
          end
        end
      end
    end
  end

  assign cnt_bcd = {hunds, tens, units};
  assign wrap    = &refresh;

  // NOTE: next-state values get defaults first so no path leaves them unassigned,
  // which would otherwise infer latches.
  always_comb begin
    sel_next = sel;
    an_next  = an_h;
    seg_next = seg_h;
    if (wrap) begin
      case (sel)
        DIG_UNITS: begin
          sel_next = DIG_TENS;
          an_next  = 3'b001;
          seg_next = {ovf, decode(units)};
        end
        DIG_TENS: begin
          sel_next = DIG_HUNDS;
          an_next  = 3'b010;
          seg_next = {1'b0, (hunds == 4'd0 && tens == 4'd0) ? 7'b0000000 : decode(tens)};
        end
        DIG_HUNDS: begin
          sel_next = DIG_UNITS;
          an_next  = 3'b100;
          seg_next = {1'b0, (hunds == 4'd0) ? 7'b0000000 : decode(hunds)};
        end
        default: begin
          sel_next = DIG_UNITS;
          an_next  = 3'b000;
          seg_next = 8'h00;
        end
      endcase
    end
  end

  // Enables and segments load on the same edge so a digit never shows a neighbour's pattern.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      refresh <= '0;
      sel     <= DIG_UNITS;
      an_h    <= 3'b000;
      seg_h   <= 8'h00;
    end else begin
      refresh <= refresh + REFRESH_BITS'(1);
      sel     <= sel_next;
      an_h    <= an_next;
      seg_h   <= seg_next;
    end
  end

  assign seg = SEG_ACTIVE_LOW ? ~seg_h : seg_h;
  assign an  = SEG_ACTIVE_LOW ? ~an_h  : an_h;

endmodule

// File: tb/tb_det_count_display.sv
// Directed bench for det_count_display: counting latency, BCD carries, overflow,
// clear priority, display multiplexing and asynchronous reset.
module tb_det_count_display;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        det = 1'b0;
  logic        clr = 1'b0;
  logic [7:0]  seg;
  logic [2:0]  an;
  logic [11:0] cnt_bcd;
  logic        ovf;

  int vectors     = 0;
  int miscompares = 0;
  int exp_cnt     = 0;
  bit exp_ovf     = 1'b0;
  logic [11:0] exp_q[$];

  det_count_display #(.REFRESH_BITS(4), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk     (clk),
    .rst     (rst),
    .det     (det),
    .clr     (clr),
    .seg     (seg),
    .an      (an),
    .cnt_bcd (cnt_bcd),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] to_bcd(input int v);
    to_bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string tag, input logic [11:0] observed, input logic [11:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One det pulse: expected count queued at drive time, compared two edges after sampling.
  task automatic pulse(input int hi, input int lo);
    logic [11:0] prev;
    prev = to_bcd(exp_cnt);
    @(negedge clk);
    det = 1'b1;
    exp_cnt++;
    if (exp_cnt == 1000) begin
      exp_cnt = 0;
      exp_ovf = 1'b1;
    end
    exp_q.push_back(to_bcd(exp_cnt));
    @(posedge clk);
    @(posedge clk);
    #1 check("cnt_hold_k1", cnt_bcd, prev);
    @(posedge clk);
    #1 check("cnt_upd_k2", cnt_bcd, exp_q.pop_front());
    if (hi > 3) repeat (hi - 3) @(negedge clk);
    @(negedge clk);
    det = 1'b0;
    repeat (lo) @(negedge clk);
    check("cnt_once", cnt_bcd, to_bcd(exp_cnt));
    check("ovf", {11'd0, ovf}, {11'd0, exp_ovf});
  endtask

  // Waits for a fresh entry into the units frame, bounded.
  task automatic wait_units_frame();
    bit seen_other;
    bit ok;
    seen_other = 1'b0;
    ok         = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (an !== 3'b110) seen_other = 1'b1;
      else if (seen_other) ok = 1'b1;
    end
    check("units_frame_seen", {11'd0, ok}, 12'd1);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cnt", cnt_bcd, 12'h000);
    check("rst_ovf", {11'd0, ovf}, 12'd0);
    check("rst_an", {9'd0, an}, {9'd0, 3'b111});
    check("rst_seg", {4'd0, seg}, {4'd0, 8'hFF});
    rst = 1'b1;

    // Display blank until the 16th edge, then units/tens/hundreds frames
    repeat (15) @(posedge clk);
    #1 check("blank_an", {9'd0, an}, {9'd0, 3'b111});
    check("blank_seg", {4'd0, seg}, {4'd0, 8'hFF});
    @(posedge clk);
    #1 check("f0_an", {9'd0, an}, {9'd0, 3'b110});
    check("f0_seg", {4'd0, seg}, {4'd0, 8'hC0});
    repeat (16) @(posedge clk);
    #1 check("f1_an", {9'd0, an}, {9'd0, 3'b101});
    check("f1_seg", {4'd0, seg}, {4'd0, 8'hFF});
    repeat (16) @(posedge clk);
    #1 check("f2_an", {9'd0, an}, {9'd0, 3'b011});
    check("f2_seg", {4'd0, seg}, {4'd0, 8'hFF});
    repeat (16) @(posedge clk);
    #1 check("f3_an", {9'd0, an}, {9'd0, 3'b110});

    // Long det levels count once each
    repeat (3) pulse(50, 5);
    check("three_long", cnt_bcd, 12'h003);

    // Preload to 109, then carry into tens
    while (exp_cnt != 109) pulse(3, 2);
    check("pre_109", cnt_bcd, 12'h109);
    pulse(3, 2);
    check("carry_110", cnt_bcd, 12'h110);

    // Up to 1000 pulses from reset: wrap and overflow
    while (!exp_ovf) pulse(3, 2);
    check("wrap_cnt", cnt_bcd, 12'h000);
    check("wrap_ovf", {11'd0, ovf}, 12'd1);
    wait_units_frame();
    check("dp_lit", {4'd0, seg}, {4'd0, 8'h40});

    // Clear resets count and overflow
    @(negedge clk);
    clr = 1'b1;
    repeat (4) @(negedge clk);
    check("clr_cnt", cnt_bcd, 12'h000);
    check("clr_ovf", {11'd0, ovf}, 12'd0);
    clr = 1'b0;
    exp_cnt = 0;
    exp_ovf = 1'b0;
    repeat (3) @(negedge clk);
    wait_units_frame();
    check("dp_off", {4'd0, seg}, {4'd0, 8'hC0});

    // Clear and det arriving together: pulse dropped
    @(negedge clk);
    clr = 1'b1;
    det = 1'b1;
    repeat (3) @(negedge clk);
    clr = 1'b0;
    repeat (4) @(negedge clk);
    check("clr_wins", cnt_bcd, 12'h000);
    det = 1'b0;
    repeat (2) @(negedge clk);
    pulse(4, 2);
    check("after_clr", cnt_bcd, 12'h001);

    // Count to 57 then reset between edges
    while (exp_cnt != 57) pulse(3, 2);
    check("pre_57", cnt_bcd, 12'h057);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check("mid_rst_cnt", cnt_bcd, 12'h000);
    check("mid_rst_ovf", {11'd0, ovf}, 12'd0);
    check("mid_rst_an", {9'd0, an}, {9'd0, 3'b111});
    check("mid_rst_seg", {4'd0, seg}, {4'd0, 8'hFF});
    @(negedge clk);
    rst = 1'b1;
    exp_cnt = 0;
    exp_ovf = 1'b0;
    pulse(4, 2);
    check("resume", cnt_bcd, 12'h001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/det_count_display.md
Name: det_count_display

Overview:
- Downstream consumer of the sequence-detector `det` output on the Mimas V2 board.
- Synchronises `det` into the 100 MHz board clock domain; the detector runs from a divided clock, so `det` is treated as asynchronous.
- Counts rising edges of `det` as a 3-digit BCD event count (000–999).
- Drives the board's multiplexed 3-digit seven-segment display with that count, with leading-zero blanking and a sticky overflow indicator.

Parameters:
- REFRESH_BITS, 16: width of the free-running refresh counter. A digit advances each time the counter wraps; 2^16 clk = 655 µs per digit at 100 MHz. Legal range is 2–24.
- SEG_ACTIVE_LOW, 1: 1 means `seg` and `an` are active-low (board default); 0 inverts both buses.

Ports:
- clk  input  1  board clock, 100 MHz; all state on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- det  input  1  detection level from the sequence detector; asynchronous to clk.
- clr  input  1  active-high count clear; asynchronous button, synchronised internally.
- seg  output 8  segment drive {dp,g,f,e,d,c,b,a}.
- an   output 3  digit enables; an[0] = units, an[1] = tens, an[2] = hundreds.
- cnt_bcd  output 12  {hundreds,tens,units} BCD count, for debug/LEDs.
- ovf  output 1  sticky flag, set when the count wraps 999→000.

Behaviour:
- Reset (rst=0, asynchronous): all synchroniser flops, the edge register, cnt_bcd, ovf, the refresh counter and the digit select go to 0. Outputs blank: seg = all segments off, an = all digits off, at inactive polarity.
- Synchronisers: two-flop synchroniser on each of `det` and `clr`. The edge register holds the previous synchronised det.
- Pulse definition: pulse = det_s2 & ~det_prev.
- Count latency: det high sampled at edge k → det_s2 high after k+1 → cnt_bcd updated at edge k+2.
  - One increment per rising edge regardless of how long det stays high.
  - Re-arms only after det_s2 has been 0 for ≥1 clk.
- BCD increment:
  - units 9 → 0 carries into tens; tens 9 → 0 carries into hundreds.
  - 999 → 000 sets ovf.
  - No digit ever holds a value above 9.
- Clear: clr_s2=1 loads cnt_bcd=000 and ovf=0 on that edge.
  - clr wins over a simultaneous pulse; that pulse is dropped.
  - Holding clr keeps the count at 000.
- Refresh counter: REFRESH_BITS wide, free-running, wraps.
  - On each wrap the digit select advances 0→1→2→0. State 3 is unreachable; if ever entered, the next advance goes to 0.
- Digit output: registered one clk after the select change, so `an` and `seg` change on the same edge (no ghosting).
  - Exactly one `an` bit is active at a time after the first refresh wrap.
  - Before the first refresh wrap the display stays blank.
- Segment decode (active-high form {g,f,e,d,c,b,a}; inverted when SEG_ACTIVE_LOW=1):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
- Leading-zero blanking:
  - Hundreds blank when its digit is 0.
  - Tens blank when hundreds and tens are both 0.
  - Units always shown.
  - Blank means all segments off, but `an` is still asserted.
- Decimal point: dp lit on digit 0 when ovf=1; otherwise off.
- Reset mid-operation: immediate return to the reset state, including mid-frame; no partial count retained.
- det glitches shorter than one clk may be missed. This is acceptable because the detector output is held for many clk.

Test Plan:
- Reset release with det=0, REFRESH_BITS=4: seg/an blank until clk 16. Then an cycles 110→101→011 every 16 clk, with seg on an[0] = 1000000 (digit 0, active-low) and tens/hundreds blank (seg=11111111).
- det pulse high for 50 clk, repeated 3 times: cnt_bcd=0x003, and each update lands exactly 2 clk after det is first sampled high. The long level does not cause multiple counts.
- Preload via 109 pulses, then one more: cnt_bcd goes 0x109→0x110, with units carry and no invalid BCD digit at any clk.
- 1000 pulses from reset: cnt_bcd=0x000, ovf=1, dp lit on an[0] frames. A following clr gives cnt_bcd=0x000, ovf=0, dp off.
- clr_s2 and a det pulse arriving on the same clk: count stays 0x000. The next det pulse after clr falls gives 0x001.
- Count at 0x057, assert rst low mid-frame (asynchronously, between clk edges): cnt_bcd=0, ovf=0, an all off immediately. After release, counting resumes from 000.
